roof_motion_sched: RTL and testbench
====================================

// Module: roof_motion_sched
// PURPOSE
//  Schedules and arbitrates the 6-bit motor/LED function word (func) that drives Motor_Control and LED_Control.
//  Sources: SPI host writes (manual) and an automatic policy from DHT11 temperature/humidity and BH1750 illumination.
//  Enforces a minimum dwell between func changes so the roof motor is never re-commanded back-to-back.
//  Sits between the SPI register bank and the motor/LED blocks; replaces direct host writes to func.
// PARAMETERS
//  DWELL_CYC  50_000_000  clk cycles a new func is held before the next change (1 s at 50 MHz); >=1
//  ILLUM_HI   16'd30000   illum strictly above this -> auto CLOSE (shade)
//  ILLUM_LO   16'd2000    illum strictly below this -> auto OPEN
//  TEMP_HI    8'd32       temp >= this -> auto OPEN (ventilate), highest auto priority
//  HUMI_HI    8'd85       humidity lock threshold (HUMI_LOCK_EN only)
//  FUNC_OPEN  6'h01 / FUNC_CLOSE 6'h02 / FUNC_STOP 6'h00   func encodings
// PORTS
//  clk          in   1   global clock (osc_clk/2)
//  rst_n        in   1   async active-low reset
//  auto_en      in   1   1 = automatic policy owns func, 0 = host owns func
//  host_wr_vld  in   1   1-cycle pulse: host wrote func register
//  host_func    in   6   value written by host, valid with host_wr_vld
//  illum_vld    in   1   1-cycle pulse: new illumination/temperature sample latched
//  illum        in   16  sampled illumination
//  temp         in   8   DHT11 temperature
//  humi         in   8   DHT11 humidity
//  func         out  6   function word to Motor_Control/LED_Control
//  func_stb     out  1   1-cycle pulse when func changes
//  func_src     out  1   source of current func: 0 host, 1 auto
//  busy         out  1   1 when state != IDLE
//  host_drop    out  1   1-cycle pulse: host write rejected
// BEHAVIOUR
//  Reset (async): state=IDLE, func=FUNC_STOP, func_src=0, func_stb=0, busy=0, host_drop=0; pending and dwell counter cleared.
//  FSM: IDLE, EVAL, APPLY, DWELL.
//  IDLE, auto_en=0, host_wr_vld: target=host_func -> APPLY. Any illum_vld in the same cycle is ignored.
//  IDLE, auto_en=1, host_wr_vld: host_drop=1 next cycle. An illum_vld in the same cycle is still taken.
//  IDLE, auto_en=1, illum_vld: -> EVAL. Inputs are registered; target is decided in EVAL, first match wins:
//    temp>=TEMP_HI -> OPEN; illum>ILLUM_HI -> CLOSE; illum<ILLUM_LO -> OPEN; otherwise keep func.
//    EVAL -> APPLY.
//  APPLY, target!=func: func<=target, func_stb=1 for 1 cycle, func_src updated, dwell counter=DWELL_CYC-1 -> DWELL.
//  APPLY, target==func: no strobe, no dwell -> IDLE.
//  Latency: host_wr_vld at cycle n -> func/func_stb at n+1. illum_vld at n -> func/func_stb at n+2.
//  DWELL: counter decrements to 0, then:
//    pending valid and auto_en=0 -> target=pending, clear pending -> APPLY;
//    otherwise clear pending -> IDLE.
//  Host write when not IDLE and auto_en=0: latched into pending; last write wins, no drop.
//  illum_vld when not IDLE: ignored; the next sample re-evaluates.
//  auto_en toggled mid-sequence: current dwell completes. Pending is applied only if auto_en=0 at DWELL end.
//  All comparisons unsigned. Counter width $clog2(DWELL_CYC+1); no wrap (saturating down-counter).
//  Reset mid-DWELL: immediate return to reset values; no strobe on release.
// CONFIGURATION
//  HUMI_LOCK_EN defined: humi>=HUMI_HI (rain/fog lock):
//    forces auto target CLOSE, ahead of the temp rule;
//    host writes of FUNC_OPEN (direct or pending) are rejected with host_drop, func unchanged.
//  HUMI_LOCK_EN undefined: humi port present but unused; no lock logic synthesized.
// TESTING (DWELL_CYC=8 for sim)
//  Reset: rst_n low mid-DWELL -> func=0, busy=0, func_stb=0 in the same cycle; no strobe after release.
//  Manual: auto_en=0, host_wr_vld host_func=6'h01 -> next cycle func=6'h01, func_stb=1, func_src=0; busy for 9 cycles.
//  Pending: second write 6'h02 then 6'h00 during DWELL -> after dwell func=6'h00, one strobe; 6'h02 never appears.
//  Auto: auto_en=1, illum=16'd40000, temp=20, illum_vld -> func=6'h02 two cycles later, func_src=1.
//  Auto: next sample illum=16'd10000 -> func unchanged, no strobe, no dwell.
//  Arbitration: auto_en=1, simultaneous host_wr_vld(6'h01) and illum_vld(illum=100) -> host_drop=1; func=6'h01 via auto, func_src=1.
//  HUMI_LOCK_EN: humi=90, auto_en=0, host_func=6'h01 -> host_drop=1, func unchanged.
//  HUMI_LOCK_EN: humi=90, auto_en=1, temp=40 sample -> func=6'h02.

Source files
------------

// File: rtl/roof_motion_sched.sv
// roof_motion_sched: arbitrates the 6-bit motor/LED function word between
// host writes and an automatic light/temperature policy, and holds every
// change for DWELL_CYC cycles before the next one may be issued.
// Build option: define HUMI_LOCK_EN to add the humidity (rain/fog) lock.
//
// Handshake: host_wr_vld and illum_vld are single-cycle qualifiers for the
// data sampled on the same rising edge; there is no back-pressure. A host
// write that cannot be taken is reported by a host_drop pulse one cycle later.
module roof_motion_sched #(
   parameter int unsigned DWELL_CYC  = 50_000_000,
   parameter logic [15:0] ILLUM_HI   = 16'd30000,
   parameter logic [15:0] ILLUM_LO   = 16'd2000,
   parameter logic [7:0]  TEMP_HI    = 8'd32,
   parameter logic [7:0]  HUMI_HI    = 8'd85,
   parameter logic [5:0]  FUNC_OPEN  = 6'h01,
   parameter logic [5:0]  FUNC_CLOSE = 6'h02,
   parameter logic [5:0]  FUNC_STOP  = 6'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        auto_en,
   input  logic        host_wr_vld,
   input  logic [5:0]  host_func,
   input  logic        illum_vld,
   input  logic [15:0] illum,
   input  logic [7:0]  temp,
   input  logic [7:0]  humi,
   output logic [5:0]  func,
   output logic        func_stb,
   output logic        func_src,
   output logic        busy,
   output logic        host_drop,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(DWELL_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_APPLY, S_DWELL} state_t;

   state_t          r_state, w_state_nxt;
   logic [5:0]      r_func, r_target, w_target_nxt, r_pend, w_pend, w_auto_tgt;
   logic            r_src, r_tsrc, w_tsrc_nxt, r_pend_vld, w_pend_vld, r_drop;
   logic [CW-1:0]   r_cnt;
   logic [15:0]     r_illum;
   logic [7:0]      r_temp;
   logic            w_lock_wr, w_lock_auto, w_host_ok, w_dwell_end, w_change;

`ifdef HUMI_LOCK_EN
   logic [7:0]      r_humi;
   assign w_lock_wr   = (humi >= HUMI_HI) && (host_func == FUNC_OPEN);
   assign w_lock_auto = (r_humi >= HUMI_HI);
`else
   logic            w_unused_humi;
   assign w_unused_humi = ^{humi, HUMI_HI};
   assign w_lock_wr     = 1'b0;
   assign w_lock_auto   = 1'b0;
`endif

   // a host write is only ever accepted while the host owns func
   assign w_host_ok   = host_wr_vld && !auto_en && !w_lock_wr;
   assign w_dwell_end = (r_state == S_DWELL) && (r_cnt == '0);
   assign w_change    = (r_state == S_APPLY) && (r_target != r_func);
   // a write arriving on the last dwell cycle counts as the latest pending one
   assign w_pend_vld  = r_pend_vld || w_host_ok;
   assign w_pend      = w_host_ok ? host_func : r_pend;

   // automatic policy on the registered sample, first matching rule wins
   always_comb begin
      w_auto_tgt = r_func;
      if (w_lock_auto)              w_auto_tgt = FUNC_CLOSE;
      else if (r_temp >= TEMP_HI)   w_auto_tgt = FUNC_OPEN;
      else if (r_illum > ILLUM_HI)  w_auto_tgt = FUNC_CLOSE;
      else if (r_illum < ILLUM_LO)  w_auto_tgt = FUNC_OPEN;
   end

   // next-state and target selection
   always_comb begin
      w_state_nxt  = r_state;
      w_target_nxt = r_target;
      w_tsrc_nxt   = r_tsrc;
      case (r_state)
         S_IDLE: begin
            if (w_host_ok) begin
               w_state_nxt  = S_APPLY;
               w_target_nxt = host_func;
               w_tsrc_nxt   = 1'b0;
            end else if (auto_en && illum_vld) begin
               w_state_nxt  = S_EVAL;
            end
         end
         S_EVAL: begin
            w_state_nxt  = S_APPLY;
            w_target_nxt = w_auto_tgt;
            w_tsrc_nxt   = 1'b1;
         end
         S_APPLY: begin
            w_state_nxt = (r_target != r_func) ? S_DWELL : S_IDLE;
         end
         S_DWELL: begin
            if (r_cnt == '0) begin
               if (w_pend_vld && !auto_en) begin
                  w_state_nxt  = S_APPLY;
                  w_target_nxt = w_pend;
                  w_tsrc_nxt   = 1'b0;
               end else begin
                  w_state_nxt  = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // state, target, committed func and dwell counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_target <= FUNC_STOP;
         r_tsrc   <= 1'b0;
         r_func   <= FUNC_STOP;
         r_src    <= 1'b0;
         r_cnt    <= '0;
         r_drop   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_target <= w_target_nxt;
         r_tsrc   <= w_tsrc_nxt;
         r_drop   <= host_wr_vld && !w_host_ok;
         if (w_change) begin
            r_func <= r_target;
            r_src  <= r_tsrc;
            r_cnt  <= CW'(DWELL_CYC - 1);
         end else if (r_state == S_DWELL && r_cnt != '0) begin
            r_cnt  <= r_cnt - CW'(1);
         end
      end
   end

   // pending host write: last write wins, dropped whenever the sequence ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_vld <= 1'b0;
         r_pend     <= FUNC_STOP;
      end else if (w_dwell_end || w_state_nxt == S_IDLE) begin
         r_pend_vld <= 1'b0;
      end else if (r_state != S_IDLE && w_host_ok) begin
         r_pend_vld <= 1'b1;
         r_pend     <= host_func;
      end
   end

   // sample capture for the EVAL decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illum <= '0;
         r_temp  <= '0;
      end else if (r_state == S_IDLE && w_state_nxt == S_EVAL) begin
         r_illum <= illum;
         r_temp  <= temp;
      end
   end

`ifdef HUMI_LOCK_EN
   // humidity captured alongside the light/temperature sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_humi <= '0;
      else if (r_state == S_IDLE && w_state_nxt == S_EVAL) r_humi <= humi;
   end
`endif

   // func shows the new target during APPLY so a host write lands one cycle later
   assign func      = w_change ? r_target : r_func;
   assign func_stb  = w_change;
   assign func_src  = w_change ? r_tsrc : r_src;
   assign busy      = (r_state != S_IDLE);
   assign host_drop = r_drop;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_roof_motion_sched.sv
// Bench for roof_motion_sched with DWELL_CYC = 8. Directed scenarios plus a
// randomized run against a timeline-based reference model.
`timescale 1ns/1ps
module tb_roof_motion_sched;

   localparam int D = 8;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        auto_en = 1'b0, host_wr_vld = 1'b0, illum_vld = 1'b0;
   logic [5:0]  host_func = '0;
   logic [15:0] illum = '0;
   logic [7:0]  temp = '0, humi = '0;
   logic [5:0]  func;
   logic        func_stb, func_src, busy, host_drop;
   logic [1:0]  dbg_state;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [9:0]  exp_q[$];

   roof_motion_sched #(.DWELL_CYC(D)) dut (
      .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .host_wr_vld(host_wr_vld),
      .host_func(host_func), .illum_vld(illum_vld), .illum(illum), .temp(temp),
      .humi(humi), .func(func), .func_stb(func_stb), .func_src(func_src),
      .busy(busy), .host_drop(host_drop), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      auto_en = 1'b0; host_wr_vld = 1'b0; illum_vld = 1'b0;
      host_func = '0; illum = 16'd10000; temp = 8'd20; humi = 8'd40;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- reference model state ----------------
   int         m_busy_end, m_apply_cyc, m_dwell_last;
   logic [5:0] m_func, m_apply_val, m_pend_val;
   logic       m_src, m_apply_src, m_pend_vld;

   task automatic model_reset();
      m_busy_end = -1; m_apply_cyc = -1; m_dwell_last = -1;
      m_func = 6'h00; m_src = 1'b0; m_pend_vld = 1'b0;
      m_apply_val = '0; m_apply_src = 1'b0; m_pend_val = '0;
   endtask

   // a change becomes visible at cycle 'at' and is then held D cycles
   task automatic model_schedule(input int at, input logic [5:0] v, input logic s);
      m_apply_cyc = at; m_apply_val = v; m_apply_src = s;
      if (v != m_func) begin
         m_busy_end = at + D; m_dwell_last = at + D;
      end else begin
         m_busy_end = at; m_dwell_last = -1;
      end
   endtask

   function automatic logic [5:0] auto_rule(input logic [15:0] il, input logic [7:0] t,
                                           input logic [7:0] h, input logic [5:0] cur);
      logic lock;
`ifdef HUMI_LOCK_EN
      lock = (h >= 8'd85);
`else
      lock = (h != h);
`endif
      if (lock)                return 6'h02;
      if (t >= 8'd32)          return 6'h01;
      if (il > 16'd30000)      return 6'h02;
      if (il < 16'd2000)       return 6'h01;
      return cur;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int strobes;
      do_reset();
      #1;
      n_cmp++; if (func !== 6'h00) begin n_fail++; $display("FAIL reset_func got=%h exp=00", func); end
      n_cmp++; if (func_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb got=%b exp=0", func_stb); end
      n_cmp++; if (func_src !== 1'b0) begin n_fail++; $display("FAIL reset_src got=%b exp=0", func_src); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (host_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b exp=0", host_drop); end
      // enter a dwell, then reset in the middle of it
      host_wr_vld = 1'b1; host_func = 6'h01;
      @(posedge clk); #1; host_wr_vld = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL middwell_busy got=%b exp=1", busy); end
      @(negedge clk); rst_n = 1'b0; #1;
      n_cmp++; if (func !== 6'h00) begin n_fail++; $display("FAIL rst_async_func got=%h exp=00", func); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
      n_cmp++; if (func_stb !== 1'b0) begin n_fail++; $display("FAIL rst_async_stb got=%b exp=0", func_stb); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      strobes = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (func_stb === 1'b1) strobes++;
      end
      n_cmp++; if (strobes != 0) begin n_fail++; $display("FAIL rst_release_strobes got=%0d exp=0", strobes); end
      n_cmp++; if (func !== 6'h00) begin n_fail++; $display("FAIL rst_release_func got=%h exp=00", func); end
   endtask

   task automatic test_manual();
      int cnt, strobes;
      do_reset();
      host_wr_vld = 1'b1; host_func = 6'h01;
      @(posedge clk); #1; host_wr_vld = 1'b0;
      n_cmp++; if (func !== 6'h01) begin n_fail++; $display("FAIL manual_func got=%h exp=01", func); end
      n_cmp++; if (func_stb !== 1'b1) begin n_fail++; $display("FAIL manual_stb got=%b exp=1", func_stb); end
      n_cmp++; if (func_src !== 1'b0) begin n_fail++; $display("FAIL manual_src got=%b exp=0", func_src); end
      cnt = 0; strobes = 0;
      while (busy === 1'b1 && cnt < 30) begin
         if (func_stb === 1'b1) strobes++;
         cnt++;
         @(posedge clk); #1;
      end
      n_cmp++; if (cnt != D + 1) begin n_fail++; $display("FAIL manual_busy_cycles got=%0d exp=%0d", cnt, D + 1); end
      n_cmp++; if (strobes != 1) begin n_fail++; $display("FAIL manual_strobes got=%0d exp=1", strobes); end
   endtask

   task automatic test_pending();
      int strobes, stb_k;
      logic saw2;
      do_reset();
      host_wr_vld = 1'b1; host_func = 6'h01;
      @(posedge clk); #1; host_wr_vld = 1'b0;   // apply cycle A
      strobes = 0; stb_k = -1; saw2 = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (func_stb === 1'b1) begin strobes++; stb_k = k; end
         if (func === 6'h02) saw2 = 1'b1;
         host_wr_vld = (k == 2) || (k == 4);
         host_func   = (k == 2) ? 6'h02 : 6'h00;
      end
      n_cmp++; if (strobes != 1) begin n_fail++; $display("FAIL pending_strobes got=%0d exp=1", strobes); end
      n_cmp++; if (stb_k != D + 1) begin n_fail++; $display("FAIL pending_strobe_cycle got=%0d exp=%0d", stb_k, D + 1); end
      n_cmp++; if (saw2 !== 1'b0) begin n_fail++; $display("FAIL pending_func02_seen got=%b exp=0", saw2); end
      n_cmp++; if (func !== 6'h00) begin n_fail++; $display("FAIL pending_final_func got=%h exp=00", func); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pending_final_busy got=%b exp=0", busy); end
   endtask

   task automatic test_auto();
      int cnt, strobes;
      do_reset();
      auto_en = 1'b1; illum = 16'd40000; temp = 8'd20; illum_vld = 1'b1;
      @(posedge clk); #1; illum_vld = 1'b0;
      n_cmp++; if (func_stb !== 1'b0 || func !== 6'h00) begin n_fail++; $display("FAIL auto_eval_cycle got func=%h stb=%b exp func=00 stb=0", func, func_stb); end
      @(posedge clk); #1;
      n_cmp++; if (func !== 6'h02) begin n_fail++; $display("FAIL auto_close_func got=%h exp=02", func); end
      n_cmp++; if (func_stb !== 1'b1) begin n_fail++; $display("FAIL auto_close_stb got=%b exp=1", func_stb); end
      n_cmp++; if (func_src !== 1'b1) begin n_fail++; $display("FAIL auto_close_src got=%b exp=1", func_src); end
      cnt = 0;
      while (busy === 1'b1 && cnt < 30) begin cnt++; @(posedge clk); #1; end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL auto_dwell_timeout busy=%b exp=0", busy); end
      // mid-band sample keeps func: no strobe and no dwell
      illum = 16'd10000; illum_vld = 1'b1;
      strobes = 0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1; illum_vld = 1'b0;
         if (func_stb === 1'b1) strobes++;
      end
      n_cmp++; if (strobes != 0) begin n_fail++; $display("FAIL auto_keep_strobes got=%0d exp=0", strobes); end
      n_cmp++; if (func !== 6'h02) begin n_fail++; $display("FAIL auto_keep_func got=%h exp=02", func); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL auto_keep_busy got=%b exp=0", busy); end
   endtask

   task automatic test_arbitration();
      do_reset();
      auto_en = 1'b1;
      host_wr_vld = 1'b1; host_func = 6'h01;
      illum_vld = 1'b1; illum = 16'd100; temp = 8'd20;
      @(posedge clk); #1; host_wr_vld = 1'b0; illum_vld = 1'b0;
      n_cmp++; if (host_drop !== 1'b1) begin n_fail++; $display("FAIL arb_drop got=%b exp=1", host_drop); end
      @(posedge clk); #1;
      n_cmp++; if (func !== 6'h01) begin n_fail++; $display("FAIL arb_func got=%h exp=01", func); end
      n_cmp++; if (func_src !== 1'b1) begin n_fail++; $display("FAIL arb_src got=%b exp=1", func_src); end
      n_cmp++; if (func_stb !== 1'b1) begin n_fail++; $display("FAIL arb_stb got=%b exp=1", func_stb); end
      n_cmp++; if (host_drop !== 1'b0) begin n_fail++; $display("FAIL arb_drop_pulse got=%b exp=0", host_drop); end
   endtask

`ifdef HUMI_LOCK_EN
   task automatic test_humi_lock();
      do_reset();
      humi = 8'd90; host_wr_vld = 1'b1; host_func = 6'h01;
      @(posedge clk); #1; host_wr_vld = 1'b0;
      n_cmp++; if (host_drop !== 1'b1) begin n_fail++; $display("FAIL lock_drop got=%b exp=1", host_drop); end
      n_cmp++; if (func !== 6'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL lock_func got=%h busy=%b exp func=00 busy=0", func, busy); end
      auto_en = 1'b1; temp = 8'd40; illum = 16'd1000; illum_vld = 1'b1;
      @(posedge clk); #1; illum_vld = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (func !== 6'h02) begin n_fail++; $display("FAIL lock_auto_func got=%h exp=02", func); end
   endtask
`endif

   task automatic test_random();
      int         c;
      logic       lock_open, acc, drop, e_stb, e_src, e_busy;
      logic [5:0] e_func;
      logic [9:0] e_v, g_v;
      do_reset();
      model_reset();
      c = 0;
      for (int i = 0; i < 1500; i++) begin
         // drive this cycle's inputs
         if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
         host_wr_vld = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0: host_func = 6'h00;
            1: host_func = 6'h01;
            2: host_func = 6'h02;
            default: host_func = 6'($urandom_range(0, 63));
         endcase
         illum_vld = ($urandom_range(0, 4) == 0);
         case ($urandom_range(0, 5))
            0: illum = 16'd30000;
            1: illum = 16'd30001;
            2: illum = 16'd2000;
            3: illum = 16'd1999;
            4: illum = 16'($urandom_range(0, 65535));
            default: illum = 16'($urandom_range(2000, 30000));
         endcase
         temp = 8'($urandom_range(25, 40));
         humi = 8'($urandom_range(80, 95));
         // reference model: decide what cycle c+1 must show
`ifdef HUMI_LOCK_EN
         lock_open = (humi >= 8'd85) && (host_func == 6'h01);
`else
         lock_open = 1'b0;
`endif
         drop = host_wr_vld && (auto_en || lock_open);
         acc  = host_wr_vld && !auto_en && !lock_open;
         if (c > m_busy_end) begin
            if (acc) model_schedule(c + 1, host_func, 1'b0);
            else if (auto_en && illum_vld) model_schedule(c + 2, auto_rule(illum, temp, humi, m_func), 1'b1);
         end else begin
            if (acc) begin m_pend_val = host_func; m_pend_vld = 1'b1; end
            if (c == m_dwell_last) begin
               if (m_pend_vld && !auto_en) model_schedule(c + 1, m_pend_val, 1'b0);
               m_pend_vld = 1'b0;
            end
            if (c == m_busy_end) m_pend_vld = 1'b0;
         end
         if (c + 1 == m_apply_cyc) begin
            e_func = m_apply_val;
            e_stb  = (m_apply_val != m_func);
            e_src  = e_stb ? m_apply_src : m_src;
            m_func = e_func; m_src = e_src;
         end else begin
            e_func = m_func; e_stb = 1'b0; e_src = m_src;
         end
         e_busy = (c + 1 <= m_busy_end);
         exp_q.push_back({e_func, e_stb, e_src, e_busy, drop});
         @(posedge clk); #1;
         c++;
         g_v = {func, func_stb, func_src, busy, host_drop};
         e_v = exp_q.pop_front();
         n_cmp++;
         if (g_v !== e_v) begin
            n_fail++;
            $display("FAIL random cyc=%0d got func=%h stb=%b src=%b busy=%b drop=%b exp func=%h stb=%b src=%b busy=%b drop=%b",
                     c, g_v[9:4], g_v[3], g_v[2], g_v[1], g_v[0], e_v[9:4], e_v[3], e_v[2], e_v[1], e_v[0]);
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      test_reset();
      test_manual();
      test_pending();
      test_auto();
      test_arbitration();
`ifdef HUMI_LOCK_EN
      test_humi_lock();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
